// File: rtl/sram_stream_reader_pkg.sv
// Shared types and constants for the SRAM burst read streamer.
package sram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ZERO = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_WIDTH  = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/sram_stream_reader_if.sv
// Command, SRAM read port and output stream of the SRAM burst reader.
interface sram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CHANNEL    = 1,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                          start;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic [LEN_WIDTH-1:0]          len;
  logic                          busy;
  logic                          done;
  logic [CHANNEL-1:0]            rd_en;
  logic [ADDR_WIDTH*CHANNEL-1:0] rd_addr;
  logic [DATA_WIDTH*CHANNEL-1:0] rd_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH*CHANNEL-1:0] out_data;
  logic                          out_last;

  modport master (
    input  start, base_addr, len, rd_data, out_ready,
    output busy, done, rd_en, rd_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, len, rd_data, out_ready,
    input  busy, done, rd_en, rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_stream_reader_fifo.sv
// Two-entry first-word-fall-through FIFO that absorbs the SRAM read latency.
module sram_rd_fifo2
  import sram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic [OCC_WIDTH-1:0] occ
);
  logic [WIDTH-1:0]     mem_reg [FIFO_DEPTH];
  logic                 wr_ptr_reg;
  logic                 rd_ptr_reg;
  logic [OCC_WIDTH-1:0] occ_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg <= occ_reg + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign occ       = occ_reg;

  // The issuer's credit rule must keep a push into a full FIFO from ever happening.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ_reg == OCC_WIDTH'(FIFO_DEPTH)));

endmodule

// File: rtl/sram_stream_reader.sv
// Issues sequential SRAM reads for a burst and returns the words as a valid/ready stream.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CHANNEL    = 1,
  parameter int SIZE       = 256,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic                  clk,
  input logic                  rst,
  sram_stream_reader_if.master bus
);
  localparam int WORD_WIDTH = DATA_WIDTH * CHANNEL;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  issued_reg, issued_next;
  logic                  done_reg, done_next;
  logic                  inflight_reg;
  logic                  inflight_last_reg;

  logic                  rd_en_w;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [OCC_WIDTH-1:0]  occ;
  logic [WORD_WIDTH:0]   head_data;
  logic                  out_valid_w;
  logic                  pop;
  logic                  credit_ok;
  logic [OCC_WIDTH:0]    committed;
  logic [CHANNEL-1:0]            rd_en_vec;
  logic [ADDR_WIDTH*CHANNEL-1:0] rd_addr_vec;

  assign out_valid_w = (occ != '0);
  assign pop         = out_valid_w && bus.out_ready;
  // Words already owed to the FIFO, net of the one leaving this cycle, must leave room.
  assign committed   = (OCC_WIDTH+1)'(occ) + (OCC_WIDTH+1)'(inflight_reg);
  assign credit_ok   = committed < ((OCC_WIDTH+1)'(FIFO_DEPTH) + (OCC_WIDTH+1)'(pop));

  if (SIZE == (1 << ADDR_WIDTH)) begin : g_mask
    assign addr_w = base_reg + issued_reg[ADDR_WIDTH-1:0];
  end else begin : g_mod
    logic [LEN_WIDTH:0] wide_sum;
    assign wide_sum = (LEN_WIDTH+1)'(base_reg) + (LEN_WIDTH+1)'(issued_reg);
    assign addr_w   = ADDR_WIDTH'(wide_sum % (LEN_WIDTH+1)'(SIZE));
  end

  always_comb begin
    state_next  = state_reg;
    base_next   = base_reg;
    len_next    = len_reg;
    issued_next = issued_reg;
    done_next   = 1'b0;
    rd_en_w     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          base_next   = bus.base_addr;
          len_next    = bus.len;
          issued_next = '0;
          state_next  = (bus.len == '0) ? ST_ZERO : ST_RUN;
        end
      end
      ST_ZERO: state_next = ST_IDLE;
      ST_RUN: begin
        rd_en_w = (issued_reg < len_reg) && credit_ok;
        if (rd_en_w) begin
          issued_next = issued_reg + LEN_WIDTH'(1);
        end
        if (pop && head_data[WORD_WIDTH]) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      base_reg          <= '0;
      len_reg           <= '0;
      issued_reg        <= '0;
      done_reg          <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      base_reg          <= base_next;
      len_reg           <= len_next;
      issued_reg        <= issued_next;
      done_reg          <= done_next;
      inflight_reg      <= rd_en_w;
      inflight_last_reg <= rd_en_w && (issued_reg == len_reg - LEN_WIDTH'(1));
    end
  end

  sram_rd_fifo2 #(
    .WIDTH(WORD_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data ({inflight_last_reg, bus.rd_data}),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  for (genvar gi = 0; gi < CHANNEL; gi++) begin : g_ch
    assign rd_en_vec[gi] = rd_en_w;
    assign rd_addr_vec[gi*ADDR_WIDTH +: ADDR_WIDTH] = rd_en_w ? addr_w : '0;
  end

  assign bus.rd_en     = rd_en_vec;
  assign bus.rd_addr   = rd_addr_vec;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_reg || (state_reg == ST_ZERO);
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = head_data[WORD_WIDTH-1:0];
  assign bus.out_last  = out_valid_w && head_data[WORD_WIDTH];

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized and directed checks of sram_stream_reader against a burst-level reference model.
module tb_sram_stream_reader;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CH = 2;
  localparam int SZ = 256;
  localparam int LW = AW + 1;
  localparam int WW = DW * CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNEL(CH), .LEN_WIDTH(LW)) bus_if ();

  sram_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNEL(CH), .SIZE(SZ), .LEN_WIDTH(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [DW-1:0] mem [CH][SZ];

  // SRAM model: one-cycle registered read per channel
  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (bus_if.rd_en[c]) bus_if.rd_data[c*DW +: DW] <= mem[c][bus_if.rd_addr[c*AW +: AW]];
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int valid_cnt = 0;
  int pops_total = 0;
  logic [WW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  int occ_m = 0;
  int infl_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] sram_word(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    for (int c = 0; c < CH; c++) w[c*DW +: DW] = mem[c][a];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       bus_if.out_ready = 1'b1;
      1:       bus_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: bus_if.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus_if.busy || bus_if.done) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout_idle", bus_if.busy, 0);
  endtask

  // Queue the expected addresses and words, then pulse start for one cycle.
  task automatic start_burst(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    wait_idle(2000);
    for (int i = 0; i < len; i++) begin
      a = AW'((int'(base) + i) % SZ);
      addr_q.push_back(a);
      exp_q.push_back({(i == len - 1), sram_word(a)});
    end
    $display("burst base=%0d len=%0d ready_mode=%0d", base, len, ready_mode);
    bus_if.start     = 1'b1;
    bus_if.base_addr = base;
    bus_if.len       = LW'(len);
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input int len);
    int d0;
    d0 = done_cnt;
    start_burst(base, len);
    wait_idle(len * 6 + 40);
    repeat (2) tick();
    check("burst_done_once", done_cnt - d0, 1);
    check("burst_words_left", exp_q.size(), 0);
    check("burst_addrs_left", addr_q.size(), 0);
  endtask

  // Protocol monitor: stream order, read addresses, fill-level timing, done pulses.
  initial begin : monitor
    logic [AW-1:0] a_m;
    bit pop;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        addr_q.delete();
        occ_m  = 0;
        infl_m = 0;
      end else begin
        pop = bus_if.out_valid && bus_if.out_ready;
        check("valid_timing", bus_if.out_valid, occ_m != 0);
        if (bus_if.out_valid) begin
          valid_cnt++;
          if (exp_q.size() == 0) check("out_extra", bus_if.out_valid, 0);
          else begin
            check("out_word", {bus_if.out_last, bus_if.out_data}, exp_q[0]);
            if (pop) begin
              void'(exp_q.pop_front());
              pops_total++;
            end
          end
        end
        if (bus_if.rd_en != '0) begin
          rd_cnt++;
          check("rd_en_lockstep", bus_if.rd_en, {CH{1'b1}});
          check("credit", (occ_m + infl_m - (pop ? 1 : 0)) < 2, 1);
          if (addr_q.size() == 0) check("rd_extra", bus_if.rd_en, 0);
          else begin
            a_m = addr_q.pop_front();
            check("rd_addr", bus_if.rd_addr, {CH{a_m}});
          end
        end
        if (bus_if.done) done_cnt++;
        occ_m  = occ_m + infl_m - (pop ? 1 : 0);
        infl_m = (bus_if.rd_en != '0) ? 1 : 0;
        if (occ_m > 2) check("occ_max", occ_m, 2);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, r0, v0, p0, n;
    bus_if.start     = 1'b0;
    bus_if.base_addr = '0;
    bus_if.len       = '0;
    bus_if.out_ready = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < SZ; a++) mem[c][a] = DW'(a + 16 * c);

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_rd_en", bus_if.rd_en, 0);
    check("rst_rd_addr", bus_if.rd_addr, 0);
    check("rst_valid", bus_if.out_valid, 0);
    check("rst_last", bus_if.out_last, 0);
    check("rst_data", bus_if.out_data, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Basic burst, cycle-exact timing
    ready_mode = 0;
    start_burst(8'd10, 4);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("t1_busy", bus_if.busy, (c <= 6));
      check("t1_done", bus_if.done, (c == 7));
      check("t1_rd_en", bus_if.rd_en[0], (c <= 4));
      check("t1_valid", bus_if.out_valid, (c >= 3 && c <= 6));
      if (c == 3) check("t1_word0", bus_if.out_data, 16'h1A0A);
      if (c == 6) check("t1_word3", {bus_if.out_last, bus_if.out_data}, 17'h11D0D);
      tick();
    end
    check("t1_words_left", exp_q.size(), 0);

    // Backpressure 1,0,0,1
    ready_mode = 1;
    run_burst(AW'($urandom), 6);

    // Zero-length burst
    ready_mode = 0;
    d0 = done_cnt; r0 = rd_cnt; v0 = valid_cnt;
    start_burst(8'd40, 0);
    @(negedge clk);
    check("t3_done", bus_if.done, 1);
    check("t3_busy", bus_if.busy, 1);
    tick();
    @(negedge clk);
    check("t3_done_end", bus_if.done, 0);
    check("t3_busy_end", bus_if.busy, 0);
    repeat (4) tick();
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_no_rd", rd_cnt - r0, 0);
    check("t3_no_valid", valid_cnt - v0, 0);

    // Address wrap
    run_burst(8'd254, 4);

    // Reset in the middle of a burst
    p0 = pops_total;
    start_burst(AW'($urandom), 8);
    n = 0;
    while (pops_total < p0 + 2 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("t5_timeout", pops_total - p0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", bus_if.busy, 0);
    check("t5_done", bus_if.done, 0);
    check("t5_rd_en", bus_if.rd_en, 0);
    check("t5_rd_addr", bus_if.rd_addr, 0);
    check("t5_valid", bus_if.out_valid, 0);
    check("t5_last", bus_if.out_last, 0);
    check("t5_data", bus_if.out_data, 0);
    repeat (4) tick();
    check("t5_no_stale", bus_if.out_valid, 0);
    run_burst(8'd0, 2);

    // start while busy must be ignored
    d0 = done_cnt;
    start_burst(8'd30, 5);
    for (int c = 1; c <= 10; c++) begin
      if (c >= 2 && c <= 4) begin
        bus_if.start     = 1'b1;
        bus_if.base_addr = 8'd99;
        bus_if.len       = LW'(3);
      end else begin
        bus_if.start = 1'b0;
      end
      tick();
    end
    repeat (4) tick();
    check("t6_done_once", done_cnt - d0, 1);
    check("t6_words_left", exp_q.size(), 0);

    // Randomized bursts over random SRAM contents
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < SZ; a++) mem[c][a] = DW'($urandom);
    for (int t = 0; t < 24; t++) begin
      ready_mode = int'($urandom_range(0, 2));
      run_burst(AW'($urandom), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20)));
    end
    ready_mode = 2;
    run_burst(AW'($urandom), SZ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
